// File: rtl/serial_bus_arbiter.sv
// Two-master serial bus arbiter: round-robin admission, bit-serial slave ID
// receive, range check, one-cycle grant, bus hold with valid timeout.
module serial_bus_arbiter #(
    parameter int SLAVE_LEN   = 2,
    parameter int SLAVE_COUNT = 3,
    parameter int TIMEOUT     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m1_request,
    input  logic                 m2_request,
    input  logic                 m1_slave_select,
    input  logic                 m2_slave_select,
    input  logic                 m1_master_valid,
    input  logic                 m2_master_valid,
    input  logic                 m1_master_ready,
    input  logic                 m2_master_ready,
    output logic                 m1_arbiter_busy,
    output logic                 m2_arbiter_busy,
    output logic                 m1_grant,
    output logic                 m2_grant,
    output logic                 reject,
    output logic                 timeout,
    output logic                 bus_busy,
    output logic                 master_sel,
    output logic [SLAVE_LEN-1:0] slave_sel,
    output logic                 slave_sel_valid
);
    localparam int BCW = $clog2(SLAVE_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [BCW-1:0]     BIT_LAST  = BCW'(SLAVE_LEN);
    localparam logic [TCW-1:0]     TO_LIMIT  = TCW'(TIMEOUT);
    localparam logic [SLAVE_LEN:0] SLV_LIMIT = (SLAVE_LEN + 1)'(SLAVE_COUNT);

    typedef enum logic [2:0] {S_IDLE, S_RX_SELECT, S_CHECK, S_GRANT, S_BUSY} state_t;

    state_t               state_q, state_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TCW-1:0]       to_cnt_q, to_cnt_d;
    logic                 last_granted_q, last_granted_d;
    logic                 valid_seen_q, valid_seen_d;
    logic                 m1_busy_q, m1_busy_d, m2_busy_q, m2_busy_d;
    logic                 m1_grant_q, m1_grant_d, m2_grant_q, m2_grant_d;
    logic                 reject_q, reject_d, timeout_q, timeout_d;
    logic                 bus_busy_q, bus_busy_d;
    logic                 master_sel_q, master_sel_d;
    logic [SLAVE_LEN-1:0] slave_sel_q, slave_sel_d;
    logic                 slave_sel_valid_q, slave_sel_valid_d;

    logic                 w_request, w_select, w_valid, w_ready, release_bus, winner;
    logic [SLAVE_LEN:0]   shift_in;

    // Only the current owner's inputs are looked at; the loser is ignored.
    assign w_request = master_sel_q ? m2_request      : m1_request;
    assign w_select  = master_sel_q ? m2_slave_select : m1_slave_select;
    assign w_valid   = master_sel_q ? m2_master_valid : m1_master_valid;
    assign w_ready   = master_sel_q ? m2_master_ready : m1_master_ready;

    always_comb begin
        state_d           = state_q;
        bit_cnt_d         = bit_cnt_q;
        to_cnt_d          = to_cnt_q;
        last_granted_d    = last_granted_q;
        valid_seen_d      = valid_seen_q;
        m1_busy_d         = m1_busy_q;
        m2_busy_d         = m2_busy_q;
        m1_grant_d        = 1'b0;
        m2_grant_d        = 1'b0;
        reject_d          = 1'b0;
        timeout_d         = 1'b0;
        bus_busy_d        = bus_busy_q;
        master_sel_d      = master_sel_q;
        slave_sel_d       = slave_sel_q;
        slave_sel_valid_d = slave_sel_valid_q;
        release_bus       = 1'b0;
        winner            = 1'b0;
        shift_in          = {w_select, slave_sel_q};

        case (state_q)
            S_IDLE: begin
                m1_busy_d         = 1'b0;
                m2_busy_d         = 1'b0;
                bus_busy_d        = 1'b0;
                slave_sel_valid_d = 1'b0;
                if (m1_request || m2_request) begin
                    winner       = m1_request ? (m2_request ? ~last_granted_q : 1'b0) : 1'b1;
                    master_sel_d = winner;
                    m1_busy_d    = winner;
                    m2_busy_d    = ~winner;
                    bit_cnt_d    = '0;
                    state_d      = S_RX_SELECT;
                end
            end
            S_RX_SELECT: begin
                if (!w_request) begin
                    m1_busy_d = 1'b0;
                    m2_busy_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    // LSB arrives first, so shift right and enter at the top.
                    slave_sel_d = shift_in[SLAVE_LEN:1];
                    bit_cnt_d   = bit_cnt_q + BCW'(1);
                    if (bit_cnt_d == BIT_LAST)
                        state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ({1'b0, slave_sel_q} >= SLV_LIMIT) begin
                    reject_d  = 1'b1;
                    m1_busy_d = 1'b0;
                    m2_busy_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    m1_grant_d        = ~master_sel_q;
                    m2_grant_d        = master_sel_q;
                    bus_busy_d        = 1'b1;
                    slave_sel_valid_d = 1'b1;
                    state_d           = S_GRANT;
                end
            end
            S_GRANT: begin
                to_cnt_d     = '0;
                valid_seen_d = 1'b0;
                state_d      = S_BUSY;
            end
            S_BUSY: begin
                if (valid_seen_q || w_valid) begin
                    valid_seen_d = 1'b1;
                    release_bus  = w_ready && !w_valid;
                end else begin
                    to_cnt_d = to_cnt_q + TCW'(1);
                    if (to_cnt_d == TO_LIMIT) begin
                        timeout_d   = 1'b1;
                        release_bus = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (release_bus) begin
            state_d           = S_IDLE;
            bus_busy_d        = 1'b0;
            slave_sel_valid_d = 1'b0;
            m1_busy_d         = 1'b0;
            m2_busy_d         = 1'b0;
            last_granted_d    = master_sel_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= S_IDLE;
            bit_cnt_q         <= '0;
            to_cnt_q          <= '0;
            last_granted_q    <= 1'b1;
            valid_seen_q      <= 1'b0;
            m1_busy_q         <= 1'b0;
            m2_busy_q         <= 1'b0;
            m1_grant_q        <= 1'b0;
            m2_grant_q        <= 1'b0;
            reject_q          <= 1'b0;
            timeout_q         <= 1'b0;
            bus_busy_q        <= 1'b0;
            master_sel_q      <= 1'b0;
            slave_sel_q       <= '0;
            slave_sel_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            bit_cnt_q         <= bit_cnt_d;
            to_cnt_q          <= to_cnt_d;
            last_granted_q    <= last_granted_d;
            valid_seen_q      <= valid_seen_d;
            m1_busy_q         <= m1_busy_d;
            m2_busy_q         <= m2_busy_d;
            m1_grant_q        <= m1_grant_d;
            m2_grant_q        <= m2_grant_d;
            reject_q          <= reject_d;
            timeout_q         <= timeout_d;
            bus_busy_q        <= bus_busy_d;
            master_sel_q      <= master_sel_d;
            slave_sel_q       <= slave_sel_d;
            slave_sel_valid_q <= slave_sel_valid_d;
        end
    end

    assign m1_arbiter_busy = m1_busy_q;
    assign m2_arbiter_busy = m2_busy_q;
    assign m1_grant        = m1_grant_q;
    assign m2_grant        = m2_grant_q;
    assign reject          = reject_q;
    assign timeout         = timeout_q;
    assign bus_busy        = bus_busy_q;
    assign master_sel      = master_sel_q;
    assign slave_sel       = slave_sel_q;
    assign slave_sel_valid = slave_sel_valid_q;
endmodule
